// File: rtl/multiplier32bu_pkg.sv
// Shared types and constants for the 32x32->64 unsigned shift-add multiplier.
package multiplier32bu_pkg;

  localparam int OP_W   = 32;
  localparam int PROD_W = 64;
  localparam int STEPS  = 32;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multiplier32bu_if.sv
// Operand/result handshake bundle between the ALU issue logic and the multiplier.
interface multiplier32bu_if;
  import multiplier32bu_pkg::*;

  logic              start;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic [PROD_W-1:0] p;
  logic              busy;
  logic              finish;

  modport master (output start, a, b, input p, busy, finish);
  modport slave  (input start, a, b, output p, busy, finish);
endinterface

// File: rtl/multiplier32bu_adder64.sv
// Combinational 64-bit unsigned adder built as two chained 32-bit halves.
module multiplier32bu_adder64
  import multiplier32bu_pkg::*;
(
  input  logic [PROD_W-1:0] x,
  input  logic [PROD_W-1:0] y,
  output logic [PROD_W-1:0] sum
);

  logic [OP_W-1:0] sum_lo;
  logic [OP_W-1:0] sum_hi;
  logic            carry_lo;

  assign {carry_lo, sum_lo} = {1'b0, x[OP_W-1:0]} + {1'b0, y[OP_W-1:0]};
  // Product never exceeds 64 bits, so the high carry-out is dropped by construction.
  assign sum_hi = x[PROD_W-1:OP_W] + y[PROD_W-1:OP_W] + {{(OP_W-1){1'b0}}, carry_lo};
  assign sum    = {sum_hi, sum_lo};

endmodule

// File: rtl/multiplier32bu.sv
// Sequential unsigned 32x32->64 shift-add multiplier, one multiplier bit per clock.
// Optional MULTIPLIER32BU_EARLY_EXIT_EN: finish as soon as the remaining multiplier is zero.
//   state  | meaning
//   S_IDLE | waiting for start
//   S_RUN  | one add/shift step per cycle
//   S_DONE | product held on p, finish high
module multiplier32bu
  import multiplier32bu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  multiplier32bu_if.slave  bus
);

  state_t             state;
  logic [PROD_W-1:0]  acc;
  logic [PROD_W-1:0]  mc;
  logic [OP_W-1:0]    m;
  logic [CNT_W-1:0]   cnt;
  logic               busy;
  logic               finish;
  logic [PROD_W-1:0]  acc_sum;
  logic               m_zero;

  multiplier32bu_adder64 u_adder (
    .x   (acc),
    .y   (mc),
    .sum (acc_sum)
  );

`ifdef MULTIPLIER32BU_EARLY_EXIT_EN
  assign m_zero = (m == '0);
`else
  assign m_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      acc    <= '0;
      mc     <= '0;
      m      <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      finish <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            acc    <= '0;
            mc     <= {{(PROD_W-OP_W){1'b0}}, bus.a};
            m      <= bus.b;
            cnt    <= CNT_W'(STEPS);
            state  <= S_RUN;
            busy   <= 1'b1;
            finish <= 1'b0;
          end
        end
        S_RUN: begin
          if (m_zero) begin
            state  <= S_DONE;
            busy   <= 1'b0;
            finish <= 1'b1;
          end else begin
            if (m[0]) acc <= acc_sum;
            mc  <= mc << 1;
            m   <= m >> 1;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state  <= S_DONE;
              busy   <= 1'b0;
              finish <= 1'b1;
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          finish <= 1'b0;
        end
      endcase
    end
  end

  assign bus.p      = acc;
  assign bus.busy   = busy;
  assign bus.finish = finish;

endmodule
